mem_port_arbiter: RTL and testbench

//  Shares one single-ported unified memory between the fetch requester (PC/fetch) and the

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_lat_cnt.sv | 27 ++
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and encodings for the memory port arbiter
package mem_arb_pkg;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Bits needed to hold values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// rtl/mem_arb_lat_cnt.sv - loadable latency down-counter, done while count is 1
module mem_arb_lat_cnt #(
  parameter int unsigned LOAD_VAL = 1,
  parameter int unsigned CNT_W    = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic done
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CNT_W'(LOAD_VAL);
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for one fixed-latency memory port
// Optional fetch starvation guard: MEM_ARB_STARVE_GUARD_EN
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
`ifdef MEM_ARB_STARVE_GUARD_EN
  ,
  parameter int unsigned STARVE_MAX = 4
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic              dm_we,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [1:0]        dm_size,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read_write,
  output logic [DATA_W-1:0] mem_data_in,
  output logic [1:0]        mem_size,
  input  logic [DATA_W-1:0] mem_data_out
);

  logic [0:0] state_q;
  owner_t     owner_q;
  logic       owner_we_q;
  logic       can_grant;
  logic       pick_if;
  logic       lat_done;

  // Grants are suppressed while reset is held so every output reads 0.
  assign can_grant = reset && (state_q == IDLE);

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned SC_W = cnt_width(STARVE_MAX);

  logic [SC_W-1:0] starve_q;
  logic            starve_hit;

  assign starve_hit = (starve_q >= SC_W'(STARVE_MAX));
  assign pick_if    = if_req && (!dm_req || starve_hit);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
    end else if (if_gnt) begin
      starve_q <= '0;
    end else if (dm_gnt) begin
      if (!if_req) begin
        starve_q <= '0;
      end else if (!starve_hit) begin
        starve_q <= starve_q + SC_W'(1);
      end
    end
  end
`else
  assign pick_if = if_req && !dm_req;
`endif

  assign if_gnt = can_grant && pick_if;
  assign dm_gnt = can_grant && dm_req && !pick_if;

  always_comb begin
    mem_valid      = 1'b0;
    mem_address    = '0;
    mem_read_write = 1'b0;
    mem_data_in    = '0;
    mem_size       = SIZE_BYTE;
    if (dm_gnt) begin
      mem_valid      = 1'b1;
      mem_address    = dm_addr;
      mem_read_write = dm_we;
      mem_data_in    = dm_wdata;
      mem_size       = dm_size;
    end else if (if_gnt) begin
      mem_valid      = 1'b1;
      mem_address    = if_addr;
      mem_size       = SIZE_WORD;
    end
  end

  mem_arb_lat_cnt #(
    .LOAD_VAL (MEM_LAT),
    .CNT_W    (cnt_width(MEM_LAT))
  ) u_lat_cnt (
    .clock (clock),
    .reset (reset),
    .load  (if_gnt || dm_gnt),
    .dec   (state_q == BUSY),
    .done  (lat_done)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_NONE;
      owner_we_q <= 1'b0;
      if_rvalid  <= 1'b0;
      dm_rvalid  <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (if_gnt || dm_gnt) begin
            state_q    <= BUSY;
            owner_q    <= dm_gnt ? OWN_DM : OWN_IF;
            owner_we_q <= dm_gnt && dm_we;
          end
        end
        default: begin
          if (lat_done) begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
            case (owner_q)
              OWN_IF: begin
                if_rvalid <= 1'b1;
                if_rdata  <= mem_data_out;
              end
              OWN_DM: begin
                dm_rvalid <= 1'b1;
                dm_rdata  <= owner_we_q ? '0 : mem_data_out;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clock;
  logic        reset;

  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [1:0]  dm_size;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid;
  logic [31:0] if_rdata, dm_rdata;
  logic        mem_valid, mem_read_write;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic [1:0]  mem_size;

  logic        if_req3, dm_req3, dm_we3;
  logic [31:0] if_addr3, dm_addr3, dm_wdata3;
  logic [1:0]  dm_size3;
  logic        if_gnt3, if_rvalid3, dm_gnt3, dm_rvalid3;
  logic [31:0] if_rdata3, dm_rdata3;
  logic        mem_valid3, mem_read_write3;
  logic [31:0] mem_address3, mem_data_in3, mem_data_out3;
  logic [1:0]  mem_size3;

  logic [31:0] mem_q1, mem_q3;

  int n_vec = 0;
  int n_bad = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_lat1 (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_we(dm_we), .dm_wdata(dm_wdata), .dm_size(dm_size),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_valid(mem_valid), .mem_address(mem_address), .mem_read_write(mem_read_write),
    .mem_data_in(mem_data_in), .mem_size(mem_size), .mem_data_out(mem_data_out)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_lat3 (
    .clock(clock), .reset(reset),
    .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .dm_req(dm_req3), .dm_addr(dm_addr3), .dm_we(dm_we3), .dm_wdata(dm_wdata3), .dm_size(dm_size3),
    .dm_gnt(dm_gnt3), .dm_rvalid(dm_rvalid3), .dm_rdata(dm_rdata3),
    .mem_valid(mem_valid3), .mem_address(mem_address3), .mem_read_write(mem_read_write3),
    .mem_data_in(mem_data_in3), .mem_size(mem_size3), .mem_data_out(mem_data_out3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory contents: address 0 holds an instruction, elsewhere a tagged pattern.
  function automatic logic [31:0] mem_func(input logic [31:0] a);
    return (a == 32'h0) ? 32'h00500093 : (32'hA5A50000 | {16'h0, a[15:0]});
  endfunction

  always @(posedge clock) begin
    if (mem_valid && !mem_read_write) mem_q1 <= mem_address;
    if (mem_valid3 && !mem_read_write3) mem_q3 <= mem_address3;
  end
  assign mem_data_out  = mem_func(mem_q1);
  assign mem_data_out3 = mem_func(mem_q3);

  typedef struct {
    logic        ir;  logic [31:0] ia;
    logic        dr;  logic [31:0] da; logic dw; logic [31:0] dd; logic [1:0] ds;
    logic        eig; logic edg; logic emv;
    logic [31:0] ema; logic emrw; logic [31:0] emd; logic [1:0] ems;
    logic        eirv; logic [31:0] eird;
    logic        edrv; logic [31:0] edrd;
  } vec_t;

  function automatic vec_t mk(
    input logic ir, input logic [31:0] ia,
    input logic dr, input logic [31:0] da, input logic dw, input logic [31:0] dd, input logic [1:0] ds,
    input logic eig, input logic edg, input logic emv,
    input logic [31:0] ema, input logic emrw, input logic [31:0] emd, input logic [1:0] ems,
    input logic eirv, input logic [31:0] eird, input logic edrv, input logic [31:0] edrd);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.da = da; v.dw = dw; v.dd = dd; v.ds = ds;
    v.eig = eig; v.edg = edg; v.emv = emv; v.ema = ema; v.emrw = emrw; v.emd = emd; v.ems = ems;
    v.eirv = eirv; v.eird = eird; v.edrv = edrv; v.edrd = edrd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_addr = '0; dm_we = 1'b0; dm_wdata = '0; dm_size = 2'd0;
  endtask

  vec_t vecs[11];
  int   gk, n_if;
  logic exp_if;
  logic [31:0] addrs3[2];
  int   ai;

  initial begin
    reset = 1'b0;
    drive_idle();
    if_req3 = 1'b0; if_addr3 = '0;
    dm_req3 = 1'b0; dm_addr3 = '0; dm_we3 = 1'b0; dm_wdata3 = '0; dm_size3 = 2'd0;

    // Outputs stay low during reset even with requests pending.
    @(negedge clock);
    if_req = 1'b1; dm_req = 1'b1; dm_addr = 32'h10;
    #2;
    chk("rst if_gnt", if_gnt, 0);
    chk("rst dm_gnt", dm_gnt, 0);
    chk("rst mem_valid", mem_valid, 0);
    chk("rst if_rvalid", if_rvalid, 0);
    chk("rst dm_rvalid", dm_rvalid, 0);
    chk("rst if_rdata", if_rdata, 0);
    chk("rst dm_rdata", dm_rdata, 0);
    @(negedge clock);
    drive_idle();
    reset = 1'b1;

    //            ir ia        dr da         dw dd            ds  eig edg emv ema        rw emd           ems eirv eird          edrv edrd
    vecs[0]  = mk(1, 32'h0,    0, 32'h0,     0, 32'h0,        0,  1,  0,  1,  32'h0,    0, 32'h0,        2,  0, 32'h0,        0, 32'h0);
    vecs[1]  = mk(0, 32'h0,    0, 32'h0,     0, 32'h0,        0,  0,  0,  0,  32'h0,    0, 32'h0,        0,  0, 32'h0,        0, 32'h0);
    vecs[2]  = mk(1, 32'h4,    1, 32'h2000,  0, 32'h0,        2,  0,  1,  1,  32'h2000, 0, 32'h0,        2,  1, 32'h00500093, 0, 32'h0);
    vecs[3]  = mk(1, 32'h4,    0, 32'h0,     0, 32'h0,        0,  0,  0,  0,  32'h0,    0, 32'h0,        0,  0, 32'h00500093, 0, 32'h0);
    vecs[4]  = mk(1, 32'h4,    0, 32'h0,     0, 32'h0,        0,  1,  0,  1,  32'h4,    0, 32'h0,        2,  0, 32'h00500093, 1, 32'hA5A52000);
    vecs[5]  = mk(0, 32'h0,    1, 32'h40,    1, 32'hDEADBEEF, 2,  0,  0,  0,  32'h0,    0, 32'h0,        0,  0, 32'h00500093, 0, 32'hA5A52000);
    vecs[6]  = mk(0, 32'h0,    1, 32'h40,    1, 32'hDEADBEEF, 2,  0,  1,  1,  32'h40,   1, 32'hDEADBEEF, 2,  1, 32'hA5A50004, 0, 32'hA5A52000);
    vecs[7]  = mk(0, 32'h0,    0, 32'h0,     0, 32'h0,        0,  0,  0,  0,  32'h0,    0, 32'h0,        0,  0, 32'hA5A50004, 0, 32'hA5A52000);
    vecs[8]  = mk(0, 32'h0,    1, 32'h3,     0, 32'h0,        0,  0,  1,  1,  32'h3,    0, 32'h0,        0,  0, 32'hA5A50004, 1, 32'h0);
    vecs[9]  = mk(0, 32'h0,    0, 32'h0,     0, 32'h0,        0,  0,  0,  0,  32'h0,    0, 32'h0,        0,  0, 32'hA5A50004, 0, 32'h0);
    vecs[10] = mk(0, 32'h0,    0, 32'h0,     0, 32'h0,        0,  0,  0,  0,  32'h0,    0, 32'h0,        0,  0, 32'hA5A50004, 1, 32'hA5A50003);

    for (int i = 0; i < 11; i++) begin
      @(negedge clock);
      if_req = vecs[i].ir; if_addr = vecs[i].ia;
      dm_req = vecs[i].dr; dm_addr = vecs[i].da; dm_we = vecs[i].dw;
      dm_wdata = vecs[i].dd; dm_size = vecs[i].ds;
      #2;
      chk($sformatf("v%0d if_gnt", i), if_gnt, vecs[i].eig);
      chk($sformatf("v%0d dm_gnt", i), dm_gnt, vecs[i].edg);
      chk($sformatf("v%0d mem_valid", i), mem_valid, vecs[i].emv);
      if (vecs[i].emv) begin
        chk($sformatf("v%0d mem_address", i), mem_address, vecs[i].ema);
        chk($sformatf("v%0d mem_read_write", i), mem_read_write, vecs[i].emrw);
        chk($sformatf("v%0d mem_data_in", i), mem_data_in, vecs[i].emd);
        chk($sformatf("v%0d mem_size", i), mem_size, vecs[i].ems);
      end
      chk($sformatf("v%0d if_rvalid", i), if_rvalid, vecs[i].eirv);
      chk($sformatf("v%0d if_rdata", i), if_rdata, vecs[i].eird);
      chk($sformatf("v%0d dm_rvalid", i), dm_rvalid, vecs[i].edrv);
      chk($sformatf("v%0d dm_rdata", i), dm_rdata, vecs[i].edrd);
    end

    // Reset while a load to 0x100 is in flight: the response must be lost.
    @(negedge clock);
    drive_idle();
    dm_req = 1'b1; dm_addr = 32'h100;
    #2;
    chk("midrst dm_gnt", dm_gnt, 1);
    @(negedge clock);
    drive_idle();
    reset = 1'b0;
    #2;
    chk("midrst dm_rvalid", dm_rvalid, 0);
    chk("midrst if_rdata", if_rdata, 0);
    chk("midrst dm_rdata", dm_rdata, 0);
    chk("midrst mem_valid", mem_valid, 0);
    @(negedge clock);
    reset = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clock);
      #2;
      chk($sformatf("midrst post%0d dm_rvalid", t), dm_rvalid, 0);
    end

    // Both requesters held high: data wins unless the starvation guard is built in.
    gk = 0; n_if = 0;
    for (int t = 0; t < 16; t++) begin
      @(negedge clock);
      dm_req = 1'b1; dm_addr = 32'h8; dm_we = 1'b0; dm_size = 2'd2;
      if_req = 1'b1; if_addr = 32'hC;
      #2;
      chk($sformatf("starve t%0d single_gnt", t), if_gnt && dm_gnt, 0);
      if (if_gnt) n_if++;
      if (if_gnt || dm_gnt) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
        exp_if = (gk == 4);
`else
        exp_if = 1'b0;
`endif
        if (gk < 6) chk($sformatf("starve grant%0d is_if", gk), if_gnt, exp_if);
        gk++;
      end
    end
    chk("starve grant_count", gk, 8);
`ifdef MEM_ARB_STARVE_GUARD_EN
    chk("starve if_total", n_if, 1);
`else
    chk("starve if_total", n_if, 0);
`endif
    @(negedge clock);
    drive_idle();
    @(negedge clock);

    // MEM_LAT=3 back-to-back fetches: grants T, T+4; responses T+4, T+8.
    addrs3[0] = 32'h0; addrs3[1] = 32'h4;
    ai = 0;
    for (int t = 0; t < 9; t++) begin
      @(negedge clock);
      if_req3  = (ai < 2);
      if_addr3 = (ai < 2) ? addrs3[ai] : 32'h0;
      #2;
      chk($sformatf("lat3 t%0d if_gnt", t), if_gnt3, (t == 0) || (t == 4));
      chk($sformatf("lat3 t%0d if_rvalid", t), if_rvalid3, (t == 4) || (t == 8));
      if (t == 4) chk("lat3 rdata0", if_rdata3, 32'h00500093);
      if (t == 8) chk("lat3 rdata1", if_rdata3, 32'hA5A50004);
      if (if_gnt3) ai++;
    end
    if_req3 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
